instr_fetch_unit: RTL and testbench

- PC register and instruction-fetch sequencer.
- Consumes the next-address value produced by the next-PC mux and holds the current PC, which is fed back to the mux as OldPC.
- Fetches each instruction word from instruction memory over a req/ack handshake and hands it to decode over a valid/ready handshake.
- Flags misaligned targets and memory timeouts with a sticky error and halts.

---
 rtl/instr_fetch_unit.sv | 151 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC register and instruction-fetch sequencer with req/ack memory and valid/ready decode handshakes
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          TIMEOUT  = 64,
    parameter int          CNT_W    = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] NewPC,
    input  logic        NewPCValid,
    output logic [15:0] OldPC,
    output logic        IMemReq,
    output logic [15:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [31:0] IMemData,
    output logic [31:0] Instruction,
    output logic        InstrValid,
    input  logic        InstrReady,
    output logic        FetchErr
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        HOLD    = 3'd2,
        WAIT_PC = 3'd3,
        HALT    = 3'd4
    } state_t;

    // Counter value seen on the TIMEOUT-th cycle spent in REQ
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t             state;
    state_t             stateNext;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cntNext;
    logic [15:0]        pcNext;
    logic               reqNext;
    logic [31:0]        instrNext;
    logic               validNext;
    logic               errNext;
    logic               pcAligned;

    // The memory address is always the held PC; it only moves when a new PC is accepted
    assign IMemAddr  = OldPC;
    assign pcAligned = (NewPC[1:0] == 2'b00);

    // State and all outputs are registered; reset is asynchronous so it aborts any request at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            OldPC       <= RESET_PC;
            IMemReq     <= 1'b0;
            Instruction <= 32'h0;
            InstrValid  <= 1'b0;
            FetchErr    <= 1'b0;
        end else begin
            state       <= stateNext;
            cnt         <= cntNext;
            OldPC       <= pcNext;
            IMemReq     <= reqNext;
            Instruction <= instrNext;
            InstrValid  <= validNext;
            FetchErr    <= errNext;
        end
    end

    // Next-state and next-output decode; every register holds its value unless a branch changes it
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        pcNext    = OldPC;
        reqNext   = IMemReq;
        instrNext = Instruction;
        validNext = InstrValid;
        errNext   = FetchErr;

        case (state)
            IDLE: begin
                stateNext = REQ;
                cntNext   = '0;
                reqNext   = 1'b1;
            end

            REQ: begin
                // An ack on the timeout edge still wins over the error
                if (IMemAck) begin
                    instrNext = IMemData;
                    validNext = 1'b1;
                    reqNext   = 1'b0;
                    stateNext = HOLD;
                end else if (cnt == CNT_LAST) begin
                    errNext   = 1'b1;
                    reqNext   = 1'b0;
                    stateNext = HALT;
                end else begin
                    cntNext   = cnt + CNT_W'(1);
                end
            end

            HOLD: begin
                if (InstrReady) begin
                    validNext = 1'b0;
                    // A new PC arriving with the handoff skips the WAIT_PC cycle
                    if (NewPCValid) begin
                        if (pcAligned) begin
                            pcNext    = NewPC;
                            cntNext   = '0;
                            reqNext   = 1'b1;
                            stateNext = REQ;
                        end else begin
                            errNext   = 1'b1;
                            stateNext = HALT;
                        end
                    end else begin
                        stateNext = WAIT_PC;
                    end
                end
            end

            WAIT_PC: begin
                if (NewPCValid) begin
                    if (pcAligned) begin
                        pcNext    = NewPC;
                        cntNext   = '0;
                        reqNext   = 1'b1;
                        stateNext = REQ;
                    end else begin
                        errNext   = 1'b1;
                        stateNext = HALT;
                    end
                end
            end

            HALT: begin
                reqNext   = 1'b0;
                validNext = 1'b0;
                errNext   = 1'b1;
            end

            default: begin
                reqNext   = 1'b0;
                validNext = 1'b0;
                errNext   = 1'b1;
                stateNext = HALT;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - vector table and directed sequences for instr_fetch_unit
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] NewPC;
    logic        NewPCValid;
    logic [15:0] OldPC;
    logic        IMemReq;
    logic [15:0] IMemAddr;
    logic        IMemAck;
    logic [31:0] IMemData;
    logic [31:0] Instruction;
    logic        InstrValid;
    logic        InstrReady;
    logic        FetchErr;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC(16'h0000),
        .TIMEOUT (4),
        .CNT_W   (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .NewPC      (NewPC),
        .NewPCValid (NewPCValid),
        .OldPC      (OldPC),
        .IMemReq    (IMemReq),
        .IMemAddr   (IMemAddr),
        .IMemAck    (IMemAck),
        .IMemData   (IMemData),
        .Instruction(Instruction),
        .InstrValid (InstrValid),
        .InstrReady (InstrReady),
        .FetchErr   (FetchErr)
    );

    int total = 0;
    int bad   = 0;
    logic invOn = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Request and valid must never be high together
    always @(negedge clk) begin
        if (invOn) begin
            total++;
            if (IMemReq && InstrValid) begin
                bad++;
                $display("FAIL inv_req_valid actual=11 required=not_both");
            end
        end
    end

    typedef struct {
        logic        rstN;
        logic        npv;
        logic [15:0] newPc;
        logic        ack;
        logic [31:0] data;
        logic        rdy;
        logic [15:0] ePc;
        logic        eReq;
        logic        eValid;
        logic [31:0] eInstr;
        logic        chkInstr;
        logic        eErr;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] IA = 32'h2008_0005;
    localparam logic [31:0] IB = 32'h8C09_0010;
    localparam logic [31:0] IC = 32'hAC0A_0020;

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        reset_n    = 1'b0;
        NewPC      = 16'h0;
        NewPCValid = 1'b0;
        IMemAck    = 1'b0;
        IMemData   = 32'h0;
        InstrReady = 1'b0;

        // rstN npv newPc ack data rdy | ePc eReq eValid eInstr chkInstr eErr
        vecs.push_back('{1'b0, 1'b0, 16'h0000, 1'b0, 32'h0, 1'b0, 16'h0000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 16'h0000, 1'b0, 32'h0, 1'b0, 16'h0000, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 16'h0000, 1'b0, 32'h0, 1'b0, 16'h0000, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 16'h0000, 1'b0, 32'h0, 1'b0, 16'h0000, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 16'h0000, 1'b1, IA,    1'b0, 16'h0000, 1'b0, 1'b1, IA,    1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 16'h0000, 1'b0, 32'h0, 1'b0, 16'h0000, 1'b0, 1'b1, IA,    1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 16'h0000, 1'b0, 32'h0, 1'b0, 16'h0000, 1'b0, 1'b1, IA,    1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 16'h0080, 1'b0, 32'h0, 1'b0, 16'h0000, 1'b0, 1'b1, IA,    1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 16'h0000, 1'b0, 32'h0, 1'b0, 16'h0000, 1'b0, 1'b1, IA,    1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 16'h0000, 1'b0, 32'h0, 1'b0, 16'h0000, 1'b0, 1'b1, IA,    1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 16'h0000, 1'b0, 32'h0, 1'b1, 16'h0000, 1'b0, 1'b0, IA,    1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 16'h0000, 1'b0, 32'h0, 1'b0, 16'h0000, 1'b0, 1'b0, IA,    1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 16'h0004, 1'b0, 32'h0, 1'b0, 16'h0004, 1'b1, 1'b0, IA,    1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 16'h0000, 1'b1, IB,    1'b0, 16'h0004, 1'b0, 1'b1, IB,    1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 16'h0040, 1'b0, 32'h0, 1'b1, 16'h0040, 1'b1, 1'b0, IB,    1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 16'h0000, 1'b0, 32'h0, 1'b0, 16'h0040, 1'b1, 1'b0, IB,    1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 16'h0000, 1'b1, IC,    1'b0, 16'h0040, 1'b0, 1'b1, IC,    1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 16'h0000, 1'b0, 32'h0, 1'b1, 16'h0040, 1'b0, 1'b0, IC,    1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 16'h0042, 1'b0, 32'h0, 1'b0, 16'h0040, 1'b0, 1'b0, IC,    1'b0, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 16'h0080, 1'b0, 32'h0, 1'b0, 16'h0040, 1'b0, 1'b0, IC,    1'b0, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 16'h00C0, 1'b1, 32'hFFFF_FFFF, 1'b1, 16'h0040, 1'b0, 1'b0, IC, 1'b0, 1'b1});

        invOn = 1'b1;
        foreach (vecs[i]) begin
            @(negedge clk);
            reset_n    = vecs[i].rstN;
            NewPCValid = vecs[i].npv;
            NewPC      = vecs[i].newPc;
            IMemAck    = vecs[i].ack;
            IMemData   = vecs[i].data;
            InstrReady = vecs[i].rdy;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.pc", i),    {16'h0, OldPC},    {16'h0, vecs[i].ePc});
            chk($sformatf("v%0d.addr", i),  {16'h0, IMemAddr}, {16'h0, vecs[i].ePc});
            chk($sformatf("v%0d.req", i),   {31'h0, IMemReq},    {31'h0, vecs[i].eReq});
            chk($sformatf("v%0d.valid", i), {31'h0, InstrValid}, {31'h0, vecs[i].eValid});
            chk($sformatf("v%0d.err", i),   {31'h0, FetchErr},   {31'h0, vecs[i].eErr});
            if (vecs[i].chkInstr)
                chk($sformatf("v%0d.instr", i), Instruction, vecs[i].eInstr);
        end

        // Timeout without ack: request held exactly TIMEOUT cycles, then sticky error
        @(negedge clk);
        NewPCValid = 1'b0;
        IMemAck    = 1'b0;
        InstrReady = 1'b0;
        reset_n    = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (IMemReq) cnt++;
            if (FetchErr) break;
        end
        chk("to.req_cycles", cnt, 4);
        chk("to.err", {31'h0, FetchErr}, 32'h1);
        chk("to.req_low", {31'h0, IMemReq}, 32'h0);

        // Async reset clears the sticky error before any clock edge
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("to.async_err_clr", {31'h0, FetchErr}, 32'h0);

        // Ack on the timeout edge wins
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        IMemAck  = 1'b1;
        IMemData = 32'h1234_5678;
        @(posedge clk);
        #1;
        chk("ack4.valid", {31'h0, InstrValid}, 32'h1);
        chk("ack4.err",   {31'h0, FetchErr},   32'h0);
        chk("ack4.instr", Instruction, 32'h1234_5678);

        // Jump to 0x0100, then reset mid-request
        @(negedge clk);
        IMemAck    = 1'b0;
        InstrReady = 1'b1;
        NewPCValid = 1'b1;
        NewPC      = 16'h0100;
        @(posedge clk);
        #1;
        chk("mid.pc",  {16'h0, OldPC}, 32'h0000_0100);
        chk("mid.req", {31'h0, IMemReq}, 32'h1);
        @(negedge clk);
        NewPCValid = 1'b0;
        InstrReady = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst.pc_async",    {16'h0, OldPC},      32'h0);
        chk("rst.req_async",   {31'h0, IMemReq},    32'h0);
        chk("rst.valid_async", {31'h0, InstrValid}, 32'h0);
        chk("rst.instr_async", Instruction,         32'h0);
        IMemAck  = 1'b1;
        IMemData = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        chk("rst.ack_ignored", {31'h0, InstrValid}, 32'h0);
        @(negedge clk);
        IMemAck = 1'b0;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel.pc",  {16'h0, OldPC},   32'h0);
        chk("rel.req", {31'h0, IMemReq}, 32'h1);
        chk("rel.err", {31'h0, FetchErr}, 32'h0);

        // Top-of-space aligned address is legal
        @(negedge clk);
        IMemAck  = 1'b1;
        IMemData = 32'h0000_0001;
        @(negedge clk);
        IMemAck    = 1'b0;
        InstrReady = 1'b1;
        NewPCValid = 1'b1;
        NewPC      = 16'hFFFC;
        @(posedge clk);
        #1;
        chk("fffc.pc",  {16'h0, OldPC},    32'h0000_FFFC);
        chk("fffc.req", {31'h0, IMemReq},  32'h1);
        chk("fffc.err", {31'h0, FetchErr}, 32'h0);

        @(negedge clk);
        invOn      = 1'b0;
        NewPCValid = 1'b0;
        InstrReady = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
